fifo_push_arbiter: RTL and testbench

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

---
 rtl/fifo_push_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_push_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that funnels four requesters into one shared FIFO push port,
// holding each grant for up to max_burst transfers before rotating.
module fifo_push_arbiter #(
    parameter int width     = 8,
    parameter int max_burst = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [3:0]           req_valid,
    input  logic [4*width-1:0]   req_data,
    output logic [3:0]           req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_push,
    output logic [width-1:0]     fifo_data,
    output logic                 grant_valid,
    output logic [1:0]           grant_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] last_beat = 4'(max_burst - 1);

    state_t     state, state_next;
    logic [1:0] ptr, ptr_next;
    logic [1:0] grant_next;
    logic [3:0] burst_cnt, burst_next;
    logic [1:0] pick_id;
    logic [1:0] cand;
    logic       pick_found;
    logic       transfer;

    // Search upward from ptr with wrap-around for the first pending requester.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = ptr;
        cand       = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign transfer    = (state == GRANT) && req_valid[grant_id] && !fifo_full;
    assign fifo_push   = transfer;
    assign grant_valid = (state == GRANT);

    always_comb begin
        req_ready = '0;
        fifo_data = '0;
        if (state == GRANT) begin
            req_ready[grant_id] = !fifo_full;
            fifo_data           = req_data[int'(grant_id)*width +: width];
        end
    end

    // A grant ends when the holder withdraws or its burst allowance is used up.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        grant_next = grant_id;
        burst_next = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_id;
                    burst_next = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (!req_valid[grant_id]) begin
                    state_next = IDLE;
                    ptr_next   = grant_id + 2'd1;
                end else if (transfer) begin
                    burst_next = burst_cnt + 4'd1;
                    if (burst_cnt == last_beat) begin
                        state_next = IDLE;
                        ptr_next   = grant_id + 2'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            grant_id  <= grant_next;
            burst_cnt <= burst_next;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed-vector bench for fifo_push_arbiter with a closing randomized handshake scoreboard.
module tb_fifo_push_arbiter;

    logic        clock;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_push;
    logic [7:0]  fifo_data;
    logic        grant_valid;
    logic [1:0]  grant_id;

    logic [7:0]  words [4];
    int          errors;
    int          checks;

    assign req_data = {words[3], words[2], words[1], words[0]};

    fifo_push_arbiter #(.width(8), .max_burst(4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_push   (fifo_push),
        .fifo_data   (fifo_data),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic gv, input logic [1:0] gid, input logic [3:0] rdy,
                                         input logic psh, input logic [7:0] d);
        return {16'h0, gv, gid, rdy, psh, d};
    endfunction

    // Check one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic apply_stimulus(input string tag, input logic gv, input logic [1:0] gid,
                                  input logic rdy, input logic psh);
        logic [31:0] exp_v;
        logic [31:0] obs_v;
        @(negedge clock);
        exp_v = pack(gv, gv ? gid : 2'd0, (gv && rdy) ? (4'b0001 << gid) : 4'b0000,
                     psh, gv ? words[gid] : 8'h00);
        obs_v = pack(grant_valid, grant_valid ? grant_id : 2'd0, req_ready, fifo_push, fifo_data);
        check_output(tag, obs_v, exp_v);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        resetn    = 1'b0;
        req_valid = 4'b0000;
        fifo_full = 1'b0;
        @(posedge clock);
        #1;
        check_output(tag, pack(grant_valid, grant_id, req_ready, fifo_push, fifo_data), 32'h0);
        resetn = 1'b1;
    endtask

    initial begin
        int order [5];
        logic [3:0] exp_rdy;
        errors    = 0;
        checks    = 0;
        resetn    = 1'b0;
        req_valid = 4'b0000;
        fifo_full = 1'b0;
        words[0]  = 8'hA0;
        words[1]  = 8'hB1;
        words[2]  = 8'hC2;
        words[3]  = 8'hD3;
        order     = '{0, 1, 2, 3, 0};

        // Lone requester 2: bubble, four pushes, bubble, four pushes; ptr then points at 3.
        do_reset("A_reset");
        req_valid = 4'b0100;
        for (int r = 0; r < 2; r++) begin
            apply_stimulus($sformatf("A_idle%0d", r), 1'b0, 2'd0, 1'b0, 1'b0);
            for (int b = 0; b < 4; b++)
                apply_stimulus($sformatf("A_push%0d_%0d", r, b), 1'b1, 2'd2, 1'b1, 1'b1);
        end
        req_valid = 4'b1100;
        apply_stimulus("A_idle_ptr3", 1'b0, 2'd0, 1'b0, 1'b0);
        apply_stimulus("A_pick3", 1'b1, 2'd3, 1'b1, 1'b1);
        req_valid = 4'b0000;
        apply_stimulus("A_drop", 1'b1, 2'd3, 1'b1, 1'b0);
        apply_stimulus("A_quiet", 1'b0, 2'd0, 1'b0, 1'b0);

        // All four requesting: grants rotate 0,1,2,3,0 with fresh data every cycle.
        do_reset("B_reset");
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            apply_stimulus($sformatf("B_idle%0d", g), 1'b0, 2'd0, 1'b0, 1'b0);
            for (int b = 0; b < 4; b++) begin
                for (int k = 0; k < 4; k++) words[k] = 8'($urandom);
                apply_stimulus($sformatf("B_g%0d_b%0d", g, b), 1'b1, 2'(order[g]), 1'b1, 1'b1);
            end
        end

        // FIFO full stalls the grant without consuming burst allowance.
        do_reset("C_reset");
        req_valid = 4'b0010;
        apply_stimulus("C_idle", 1'b0, 2'd0, 1'b0, 1'b0);
        apply_stimulus("C_push0", 1'b1, 2'd1, 1'b1, 1'b1);
        apply_stimulus("C_push1", 1'b1, 2'd1, 1'b1, 1'b1);
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++)
            apply_stimulus($sformatf("C_stall%0d", s), 1'b1, 2'd1, 1'b0, 1'b0);
        fifo_full = 1'b0;
        apply_stimulus("C_push2", 1'b1, 2'd1, 1'b1, 1'b1);
        apply_stimulus("C_push3", 1'b1, 2'd1, 1'b1, 1'b1);
        apply_stimulus("C_end", 1'b0, 2'd0, 1'b0, 1'b0);

        // Requester 3 drops early (with FIFO full); ptr wraps so 0 beats 3 next.
        do_reset("D_reset");
        req_valid = 4'b1000;
        apply_stimulus("D_idle", 1'b0, 2'd0, 1'b0, 1'b0);
        apply_stimulus("D_push", 1'b1, 2'd3, 1'b1, 1'b1);
        req_valid = 4'b0001;
        fifo_full = 1'b1;
        apply_stimulus("D_drop", 1'b1, 2'd3, 1'b0, 1'b0);
        req_valid = 4'b1001;
        fifo_full = 1'b0;
        apply_stimulus("D_idle2", 1'b0, 2'd0, 1'b0, 1'b0);
        apply_stimulus("D_pick0", 1'b1, 2'd0, 1'b1, 1'b1);

        // Reset two beats into a burst; afterwards requester 0 wins and gets a full burst.
        do_reset("E_reset");
        req_valid = 4'b0110;
        apply_stimulus("E_idle", 1'b0, 2'd0, 1'b0, 1'b0);
        apply_stimulus("E_push0", 1'b1, 2'd1, 1'b1, 1'b1);
        apply_stimulus("E_push1", 1'b1, 2'd1, 1'b1, 1'b1);
        resetn = 1'b0;
        #1;
        check_output("E_rst_now", pack(grant_valid, grant_id, req_ready, fifo_push, fifo_data), 32'h0);
        @(posedge clock);
        #1;
        check_output("E_rst_hold", pack(grant_valid, grant_id, req_ready, fifo_push, fifo_data), 32'h0);
        resetn    = 1'b1;
        req_valid = 4'b0111;
        apply_stimulus("E_idle2", 1'b0, 2'd0, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++)
            apply_stimulus($sformatf("E_g0_b%0d", b), 1'b1, 2'd0, 1'b1, 1'b1);
        apply_stimulus("E_idle3", 1'b0, 2'd0, 1'b0, 1'b0);
        apply_stimulus("E_pick1", 1'b1, 2'd1, 1'b1, 1'b1);

        // Random traffic: every push must be exactly one accepted handshake carrying its word.
        do_reset("F_reset");
        for (int c = 0; c < 2000; c++) begin
            req_valid = 4'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) words[k] = 8'($urandom);
            @(negedge clock);
            exp_rdy = (grant_valid && !fifo_full) ? (4'b0001 << grant_id) : 4'b0000;
            check_output($sformatf("F_ready%0d", c), {28'h0, req_ready}, {28'h0, exp_rdy});
            check_output($sformatf("F_push%0d", c), {31'h0, fifo_push},
                         {31'h0, (|(req_valid & exp_rdy)) && !fifo_full});
            if (fifo_push)
                check_output($sformatf("F_data%0d", c), {24'h0, fifo_data}, {24'h0, words[grant_id]});
            @(posedge clock);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
